unidade_pc: RTL

Parametrised program-counter unit: holds the PC register and computes the next PC each clock. It generalises the fixed PC+4 adder with configurable width and step, stall, relative branch, absolute jump, and an optional return-address stack for call/return. It sits at the head of the fetch stage and drives the instruction-memory address.

---
 rtl/unidade_pc.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/unidade_pc.sv
// Program-counter unit: PC register, next-PC selection (stall/return/call/jump/branch/sequential)
// and an optional circular return-address stack built only when PILHA_RET_EN is defined.
module unidade_pc #(
  parameter int LARGURA    = 32,
  parameter int PASSO      = 4,
  parameter int RESET_PC   = 0,
  parameter int PROF_PILHA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               desvio,
  input  logic [LARGURA-1:0] offset,
  input  logic               salto,
  input  logic               chamada,
  input  logic               retorno,
  input  logic [LARGURA-1:0] alvo,
  output logic [LARGURA-1:0] PC,
  output logic [LARGURA-1:0] PC4,
  output logic               pilha_vazia,
  output logic               pilha_cheia,
  output logic               erro_pilha
);

  localparam logic [LARGURA-1:0] PASSO_V = LARGURA'(PASSO);
  localparam logic [LARGURA-1:0] RESET_V = LARGURA'(RESET_PC);

  if (PROF_PILHA < 2) begin : g_prof_invalida
    $error("PROF_PILHA must be at least 2");
  end

  // Modular sum; carry out is dropped so addresses wrap at 2^LARGURA.
  function automatic logic [LARGURA-1:0] soma_wrap(input logic [LARGURA-1:0] a,
                                                   input logic signed [LARGURA-1:0] b);
    logic signed [LARGURA:0] s;
    s = $signed({1'b0, a}) + (LARGURA+1)'(b);
    return s[LARGURA-1:0];
  endfunction

  logic [LARGURA-1:0]        pc_p0, pc_nxt, pc4;
  logic signed [LARGURA-1:0] offset_s, passo_s;

  assign offset_s = offset;
  assign passo_s  = PASSO_V;
  assign pc4      = soma_wrap(pc_p0, passo_s);
  assign PC       = pc_p0;
  assign PC4      = pc4;

`ifdef PILHA_RET_EN
  localparam int PW = (PROF_PILHA > 1) ? $clog2(PROF_PILHA) : 1;
  localparam int CW = $clog2(PROF_PILHA + 1);
  localparam logic [CW-1:0] CHEIO = CW'(PROF_PILHA);
  localparam logic [PW-1:0] ULT   = PW'(PROF_PILHA - 1);

  logic [LARGURA-1:0] pilha_mem [PROF_PILHA];
  logic [PW-1:0]      topo_p0, topo_nxt, topo_inc, topo_dec;
  logic [CW-1:0]      cont_p0, cont_nxt;
  logic               erro_p0, erro_nxt, push;

  // topo_p0 points at the newest entry; wrapping overwrites the oldest one.
  assign topo_inc = (topo_p0 == ULT) ? '0 : topo_p0 + 1'b1;
  assign topo_dec = (topo_p0 == '0) ? ULT : topo_p0 - 1'b1;

  always_comb begin
    pc_nxt   = pc4;
    topo_nxt = topo_p0;
    cont_nxt = cont_p0;
    erro_nxt = 1'b0;
    push     = 1'b0;
    if (stall) begin
      pc_nxt = pc_p0;
    end else if (retorno) begin
      if (cont_p0 != '0) begin
        pc_nxt   = pilha_mem[topo_p0];
        topo_nxt = topo_dec;
        cont_nxt = cont_p0 - 1'b1;
      end else begin
        erro_nxt = 1'b1;
      end
    end else if (chamada) begin
      pc_nxt   = alvo;
      push     = 1'b1;
      topo_nxt = topo_inc;
      if (cont_p0 == CHEIO) erro_nxt = 1'b1;
      else                  cont_nxt = cont_p0 + 1'b1;
    end else if (salto) begin
      pc_nxt = alvo;
    end else if (desvio) begin
      pc_nxt = soma_wrap(pc_p0, offset_s);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_p0   <= RESET_V;
      topo_p0 <= '0;
      cont_p0 <= '0;
      erro_p0 <= 1'b0;
    end else begin
      pc_p0   <= pc_nxt;
      topo_p0 <= topo_nxt;
      cont_p0 <= cont_nxt;
      erro_p0 <= erro_nxt;
    end
  end

  // Storage is data only; an emptied count makes stale entries unreachable.
  always_ff @(posedge clock) begin
    if (push) pilha_mem[topo_nxt] <= pc4;
  end

  assign pilha_vazia = (cont_p0 == '0);
  assign pilha_cheia = (cont_p0 == CHEIO);
  assign erro_pilha  = erro_p0;
`else
  always_comb begin
    pc_nxt = pc4;
    if (stall) begin
      pc_nxt = pc_p0;
    end else if (chamada || salto) begin
      pc_nxt = alvo;
    end else if (desvio) begin
      pc_nxt = soma_wrap(pc_p0, offset_s);
    end else begin
      // Without a stack a return is just another sequential step.
      pc_nxt = retorno ? pc4 : pc4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) pc_p0 <= RESET_V;
    else       pc_p0 <= pc_nxt;
  end

  assign pilha_vazia = 1'b1;
  assign pilha_cheia = 1'b0;
  assign erro_pilha  = 1'b0;
`endif

endmodule
